// File: rtl/receiver.sv
// rtl/receiver.sv - 8N1 UART receive path, LSB first, mid-bit sampling
module receiver #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  output logic [7:0] rx_data,
  output logic       data_valid,
  output logic       framing_error,
  output logic       busy
);

  localparam logic [13:0] BIT_LAST  = 14'(CLKS_PER_BIT - 1);
  localparam logic [13:0] HALF_LAST = 14'(HALF_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        rx_meta;
  logic        rx_s;
  logic        rx_prev;
  logic [13:0] counter;
  logic [3:0]  bit_idx;
  logic [7:0]  shift_reg;

  logic        falling;
  logic        half_hit;
  logic        bit_hit;
  logic        enter_data;
  logic        take_bit;
  logic        good_stop;
  logic        bad_stop;

  // Flops reset to the idle line level so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RxD;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign falling  = rx_prev && !rx_s;
  assign half_hit = (counter == HALF_LAST);
  assign bit_hit  = (counter == BIT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (falling) state_next = START;
      START: if (half_hit) state_next = rx_s ? IDLE : DATA;
      DATA:  if (bit_hit && bit_idx == 4'd7) state_next = STOP;
      STOP:  if (bit_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    enter_data = 1'b0;
    take_bit   = 1'b0;
    good_stop  = 1'b0;
    bad_stop   = 1'b0;
    case (state)
      IDLE: ;
      START: begin
        busy       = 1'b1;
        enter_data = half_hit && !rx_s;
      end
      DATA: begin
        busy     = 1'b1;
        take_bit = bit_hit;
      end
      STOP: begin
        busy      = 1'b1;
        good_stop = bit_hit && rx_s;
        bad_stop  = bit_hit && !rx_s;
      end
      default: busy = 1'b0;
    endcase
  end

  // Counter restarts on every state change and at each data-bit sample point.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter       <= 14'd0;
      bit_idx       <= 4'd0;
      shift_reg     <= 8'h00;
      rx_data       <= 8'h00;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if (state_next != state || take_bit || state == IDLE) begin
        counter <= 14'd0;
      end else begin
        counter <= counter + 14'd1;
      end

      if (enter_data) begin
        bit_idx <= 4'd0;
      end else if (take_bit) begin
        bit_idx <= bit_idx + 4'd1;
      end

      if (take_bit) begin
        shift_reg <= {rx_s, shift_reg[7:1]};
      end

      if (good_stop) begin
        rx_data <= shift_reg;
      end
      data_valid    <= good_stop;
      framing_error <= bad_stop;
    end
  end

endmodule

// File: tb/tb_receiver.sv
// tb/tb_receiver.sv - randomized directed bench for the UART receiver
module tb_receiver;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       RxD = 1'b1;
  logic [7:0] rx_data;
  logic       data_valid;
  logic       framing_error;
  logic       busy;

  receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .reset         (reset),
    .RxD           (RxD),
    .rx_data       (rx_data),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] dv_data[$];
  int         dv_cyc[$];
  int         fe_cyc[$];
  int         both_hi = 0;
  int         busy_hi = 0;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_data.push_back(rx_data);
      dv_cyc.push_back(cyc);
    end
    if (framing_error) fe_cyc.push_back(cyc);
    if (data_valid && framing_error) both_hi = both_hi + 1;
    if (busy) busy_hi = busy_hi + 1;
  end

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  int         exp_cyc[$];
  int         fe_exp = 0;
  int         dv_base = 0;
  int         fe_base = 0;
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    vectors = vectors + 1;
    assert (obs >= lo && obs <= hi) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame driven as nominal bit edges plus an optional random offset on each inner edge.
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit jit);
    int   off[11];
    logic b[10];
    b[0] = 1'b0;
    for (int k = 0; k < 8; k++) b[k+1] = d[k];
    b[9] = stop;
    off[0]  = 0;
    off[10] = 0;
    for (int k = 1; k < 10; k++) off[k] = jit ? int'($urandom_range(6)) - 3 : 0;
    if (stop) begin
      exp_q.push_back(d);
      exp_cyc.push_back(cyc + LAT);
      last_good = d;
    end else begin
      fe_exp = fe_exp + 1;
    end
    for (int k = 0; k < 10; k++) begin
      RxD = b[k];
      wait_cycles(CPB + off[k+1] - off[k]);
    end
  endtask

  task automatic check_frames(input string tag);
    int n;
    n = dv_data.size() - dv_base;
    chk({tag, "_nvalid"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      chk({tag, "_data"}, dv_data[dv_base+i], exp_q[i]);
      chk_rng({tag, "_latency"}, dv_cyc[dv_base+i] - exp_cyc[i], -2, 2);
    end
    chk({tag, "_nferr"}, fe_cyc.size() - fe_base, fe_exp);
    dv_base = dv_data.size();
    fe_base = fe_cyc.size();
    exp_q.delete();
    exp_cyc.delete();
    fe_exp = 0;
  endtask

  initial begin
    int b0;
    int bh;

    wait_cycles(5);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_ferr", framing_error, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b1;
    wait_cycles(3);

    RxD = 1'b0; wait_cycles(CPB);
    RxD = 1'b1; wait_cycles(CPB);
    RxD = 1'b0; wait_cycles(3 * CPB);
    chk("midframe_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rx_data", rx_data, 8'h00);
    chk("midrst_valid", data_valid, 1'b0);
    chk("midrst_ferr", framing_error, 1'b0);
    @(negedge clk);
    RxD = 1'b1;
    wait_cycles(4);
    reset = 1'b1;
    wait_cycles(2 * CPB);
    check_frames("midrst");

    send_frame(8'hA5, 1'b1, 1'b0);
    RxD = 1'b1;
    wait_cycles(2 * CPB);
    check_frames("single");
    chk("single_hold", rx_data, 8'hA5);

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1, 1'b0);
    RxD = 1'b1;
    wait_cycles(2 * CPB);
    for (int i = dv_base + 1; i < dv_data.size(); i++)
      chk_rng("b2b_interval", dv_cyc[i] - dv_cyc[i-1], 10 * CPB - 2, 10 * CPB + 2);
    check_frames("b2b");

    send_frame(8'h55, 1'b0, 1'b0);
    b0 = busy_hi;
    wait_cycles(40 * CPB);
    chk("break_busy", busy_hi - b0, 0);
    check_frames("break");
    chk("break_hold", rx_data, last_good);
    RxD = 1'b1;
    wait_cycles(2 * CPB);
    send_frame(8'($urandom), 1'b1, 1'b0);
    RxD = 1'b1;
    wait_cycles(2 * CPB);
    check_frames("after_break");

    b0 = busy_hi;
    RxD = 1'b0; wait_cycles(4);
    RxD = 1'b1; wait_cycles(3 * CPB);
    bh = busy_hi - b0;
    chk_rng("glitch_busy", bh, HALF - 2, HALF + 2);
    check_frames("glitch");
    chk("glitch_hold", rx_data, last_good);

    send_frame(8'h81, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1, 1'b1);
    RxD = 1'b1;
    wait_cycles(2 * CPB);
    check_frames("jitter");

    chk("both_strobes", both_hi, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/receiver.md
Name: receiver

Overview:
- UART receive path, 8N1 framing, LSB first; the counterpart of the team's UART transmitter.
- Defaults: 100 MHz clk, 9600 baud.
- Sits between the external serial pin RxD and on-chip consumer logic.
- Operation: synchronises RxD, detects the start bit, samples each bit at mid-period, checks the stop bit, then presents one byte with a single-cycle valid strobe or a single-cycle framing-error strobe.

Parameters:
- CLKS_PER_BIT, 10416: clk cycles per bit period (100_000_000 / 9600). Legal range 4..16383. The bench overrides it to 16.
- HALF_BIT, CLKS_PER_BIT/2: cycles from the start-bit edge to the start-bit mid-sample. Integer division.

Ports:
- clk  input  1  system clock, all logic on the rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- RxD  input  1  serial line, idle high, asynchronous to clk
- rx_data  output  8  last correctly framed byte, held until the next good byte
- data_valid  output  1  one-cycle pulse when rx_data updates
- framing_error  output  1  one-cycle pulse when the stop bit is sampled low
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, async), all outputs and registers:
  - rx_data=0x00, data_valid=0, framing_error=0, busy=0.
  - state=IDLE, counter=0, bit index=0, shift register=0x00.
  - Synchroniser flops and the previous-sample flop reset to 1.
- Reset mid-frame abandons the frame immediately. No strobe is produced for it.
- Synchroniser:
  - Two-flop synchroniser on RxD produces rx_s. This adds 2 cycles of latency.
  - A third flop holds rx_s from the previous cycle, for edge detection.
- Counter: 14-bit baud counter. It is cleared on every state transition and counts up while in START, DATA or STOP.
- IDLE:
  - Waits for a falling edge: previous rx_s=1 and current rx_s=0.
  - A line that is low without a preceding high does not start a frame. A continuous break after a framing error therefore does not re-trigger.
  - On a falling edge: go to START with counter=0.
- START:
  - When counter==HALF_BIT-1, sample rx_s.
  - If rx_s=0: go to DATA, counter=0, bit index=0.
  - If rx_s=1 (glitch / false start): go to IDLE with no strobe.
- DATA:
  - When counter==CLKS_PER_BIT-1, sample rx_s and shift it in at the MSB (shift register right-shifts), then increment the bit index.
  - After the 8th sample (bit index 7 -> 8): go to STOP, counter=0.
  - After the 8 samples, bit 0 of the serial stream is in shift register bit 0.
- STOP:
  - When counter==CLKS_PER_BIT-1, sample rx_s.
  - If rx_s=1: rx_data <= shift register, data_valid=1 for exactly 1 cycle.
  - If rx_s=0: framing_error=1 for exactly 1 cycle; rx_data unchanged.
  - Either way, go to IDLE on the same edge.
- Strobes:
  - data_valid and framing_error are never high together.
  - Neither is high outside the cycle after the stop sample.
- Latency: the strobe rises 2 + HALF_BIT + 9*CLKS_PER_BIT cycles (±2) after the RxD falling edge, i.e. at mid-stop-bit.
- Back-to-back frames:
  - A start bit that begins right at the end of a stop bit is received correctly.
  - This holds because IDLE is re-entered at mid-stop, before the next falling edge.
- Width rules:
  - counter is 14 bits and compares against CLKS_PER_BIT-1 with no overflow.
  - Bit index is 4 bits.
- No buffering: a byte not consumed is overwritten by the next good byte.
- No overrun flag.

Test Plan:
All scenarios use CLKS_PER_BIT=16.
1. Reset: reset=0 mid-frame, then release -> rx_data=0x00, data_valid=0, framing_error=0, busy=0; next good frame is received normally.
2. Single frame 0xA5 driven LSB first at 16 clk/bit -> exactly one data_valid pulse 2+8+144 (±2) cycles after the start edge; rx_data=0xA5; framing_error never high.
3. Back-to-back 0x00, 0xFF, 0x3C with no idle gap -> three data_valid pulses 160 (±2) cycles apart; rx_data sequence 0x00, 0xFF, 0x3C.
4. Frame 0x55 with the stop bit driven low, then the line held low for 40 bits -> one framing_error pulse; rx_data keeps its prior value; no further strobes or busy until the line goes high and a new falling edge occurs.
5. 4-cycle low glitch on an idle line -> busy high for ~8 cycles then low; no strobes; rx_data unchanged.
6. Frame 0x81 with every bit edge jittered ±3 cycles -> rx_data=0x81, data_valid pulse, no framing_error.
